// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher
//   Sequencer between the UART frame parser and the command handlers. A good
//   frame's command byte selects one handler channel; the frame payload is then
//   streamed out of the parser's payload buffer as a valid/ready byte stream.
//   Frames arriving mid-dispatch are dropped (overrun), and a dispatch that a
//   handler stalls for TIMEOUT_CYCLES consecutive cycles is aborted.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   parse_done            good-frame pulse, cmd_in/len_in valid with it
//   parse_error           rejected-frame pulse (only counted)
//   cmd_in, len_in        command byte and payload length
//   payload_read_addr     read address into the parser payload buffer
//   payload_read_data     buffer data, combinational from payload_read_addr
//   handler_start         one-hot start pulse to the selected handler
//   cmd_len               length of the current dispatch
//   out_data/out_valid/out_last, out_ready   payload byte stream
//   busy                  dispatch in progress
//   dispatch_done         normal completion pulse
//   err_unknown_cmd, err_overrun, err_timeout   error pulses
//   err_count             saturating error counter
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for parse_done; validates cmd and length
// START   | one-cycle handler_start pulse, read address cleared
// STREAM  | presenting payload bytes until the last beat transfers
// FINISH  | one-cycle dispatch_done pulse, then back to IDLE

module cmd_dispatcher #(
  parameter int NUM_HANDLERS    = 4,
  parameter int MAX_PAYLOAD_LEN = 256,
  parameter int ADDR_WIDTH      = $clog2(MAX_PAYLOAD_LEN),
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    parse_done,
  input  logic                    parse_error,
  input  logic [7:0]              cmd_in,
  input  logic [15:0]             len_in,
  output logic [ADDR_WIDTH-1:0]   payload_read_addr,
  input  logic [7:0]              payload_read_data,
  output logic [NUM_HANDLERS-1:0] handler_start,
  output logic [15:0]             cmd_len,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic [NUM_HANDLERS-1:0] out_ready,
  output logic                    busy,
  output logic                    dispatch_done,
  output logic                    err_unknown_cmd,
  output logic                    err_overrun,
  output logic                    err_timeout,
  output logic [7:0]              err_count
);

  localparam int SEL_W = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;
  localparam logic [7:0]              NUM_H8      = 8'(NUM_HANDLERS);
  localparam logic [15:0]             MAX_LEN16   = 16'(MAX_PAYLOAD_LEN);
  localparam logic [15:0]             STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_HANDLERS-1:0] ONE_HOT_LSB = NUM_HANDLERS'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_STREAM = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           stall_q, stall_d;
  logic                  unk_q, unk_d;
  logic                  ovr_q, ovr_d;
  logic                  tmo_q, tmo_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  cmd_ok;
  logic                  beat_last;
  logic                  any_err;

  assign cmd_ok    = (cmd_in != 8'd0) && (cmd_in <= NUM_H8) && (len_in <= MAX_LEN16);
  // Last beat when addr == len-1; only evaluated in STREAM where len >= 1.
  assign beat_last = (16'(addr_q) == (len_q - 16'd1));
  assign any_err   = unk_q | ovr_q | tmo_q | parse_error;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    len_d         = len_q;
    addr_d        = addr_q;
    stall_d       = stall_q;
    unk_d         = 1'b0;
    ovr_d         = 1'b0;
    tmo_d         = 1'b0;
    handler_start = '0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    dispatch_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (parse_done) begin
          len_d = len_in;
          sel_d = SEL_W'(cmd_in - 8'd1);
          if (cmd_ok) state_d = S_START;
          else        unk_d   = 1'b1;
        end
      end
      S_START: begin
        handler_start = ONE_HOT_LSB << sel_q;
        addr_d        = '0;
        stall_d       = '0;
        state_d       = (len_q == 16'd0) ? S_FINISH : S_STREAM;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        out_last  = beat_last;
        if (out_ready[sel_q]) begin
          stall_d = '0;
          if (beat_last) begin
            // Park the address at 0 instead of stepping past the buffer end.
            addr_d  = '0;
            state_d = S_FINISH;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end else if (stall_q == STALL_LIMIT) begin
          stall_d = '0;
          addr_d  = '0;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      S_FINISH: begin
        dispatch_done = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A frame arriving while a dispatch is active is dropped, not queued.
    if (parse_done && (state_q != S_IDLE)) ovr_d = 1'b1;

    err_cnt_d = err_cnt_q;
    if (any_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      stall_q   <= '0;
      unk_q     <= 1'b0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      stall_q   <= stall_d;
      unk_q     <= unk_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign payload_read_addr = addr_q;
  assign out_data          = payload_read_data;
  assign cmd_len           = len_q;
  assign busy              = (state_q != S_IDLE);
  assign err_unknown_cmd   = unk_q;
  assign err_overrun       = ovr_q;
  assign err_timeout       = tmo_q;
  assign err_count         = err_cnt_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
module tb_cmd_dispatcher;

  localparam int NH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        parse_done;
  logic        parse_error;
  logic [7:0]  cmd_in;
  logic [15:0] len_in;
  logic [7:0]  payload_read_addr;
  logic [7:0]  payload_read_data;
  logic [NH-1:0] handler_start;
  logic [15:0] cmd_len;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [NH-1:0] out_ready;
  logic        busy;
  logic        dispatch_done;
  logic        err_unknown_cmd;
  logic        err_overrun;
  logic        err_timeout;
  logic [7:0]  err_count;

  logic [7:0]  mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  assign payload_read_data = mem[payload_read_addr];

  always #5 clk = ~clk;

  cmd_dispatcher #(
    .NUM_HANDLERS   (NH),
    .MAX_PAYLOAD_LEN(256),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .parse_done       (parse_done),
    .parse_error      (parse_error),
    .cmd_in           (cmd_in),
    .len_in           (len_in),
    .payload_read_addr(payload_read_addr),
    .payload_read_data(payload_read_data),
    .handler_start    (handler_start),
    .cmd_len          (cmd_len),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_last         (out_last),
    .out_ready        (out_ready),
    .busy             (busy),
    .dispatch_done    (dispatch_done),
    .err_unknown_cmd  (err_unknown_cmd),
    .err_overrun      (err_overrun),
    .err_timeout      (err_timeout),
    .err_count        (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] pat;
    int idx;
    int got;
    int ovr_seen;
    int start_seen;
    int done_seen;
    logic [7:0] prev_data;

    rst = 1'b1; parse_done = 1'b0; parse_error = 1'b0;
    cmd_in = 8'h00; len_in = 16'h0000; out_ready = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(); tick();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_start", handler_start, 0);
    chk("rst_cmd_len", cmd_len, 0);
    chk("rst_addr", payload_read_addr, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_done", dispatch_done, 0);
    rst = 1'b0;
    tick();

    // cmd 2, len 3, ready high
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
    out_ready = 4'hF;
    parse_done = 1'b1; cmd_in = 8'h02; len_in = 16'd3;
    tick();                                   // T+1
    parse_done = 1'b0;
    chk("t1_start", handler_start, 4'b0010);
    chk("t1_busy", busy, 1);
    chk("t1_valid_t1", out_valid, 0);
    chk("t1_cmd_len", cmd_len, 3);
    tick();                                   // T+2
    chk("t1_b0_valid", out_valid, 1);
    chk("t1_b0_data", out_data, 8'hA1);
    chk("t1_b0_last", out_last, 0);
    chk("t1_start_off", handler_start, 0);
    tick();
    chk("t1_b1_data", out_data, 8'hB2);
    chk("t1_b1_last", out_last, 0);
    tick();
    chk("t1_b2_data", out_data, 8'hC3);
    chk("t1_b2_last", out_last, 1);
    tick();                                   // T+5
    chk("t1_done", dispatch_done, 1);
    chk("t1_valid_off", out_valid, 0);
    chk("t1_busy_finish", busy, 1);
    tick();
    chk("t1_busy_low", busy, 0);
    chk("t1_done_off", dispatch_done, 0);
    chk("t1_err_count", err_count, 0);

    // cmd 1, len 4, ready[0] pattern 1,0,0,1; other ready bits held high
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    out_ready = 4'h0;
    parse_done = 1'b1; cmd_in = 8'h01; len_in = 16'd4;
    tick();
    parse_done = 1'b0;
    chk("t2_start", handler_start, 4'b0001);
    tick();
    pat = 4'b1001;
    idx = 0; done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      out_ready = {3'b111, pat[k % 4]};
      if (dispatch_done) begin
        done_seen = 1;
        break;
      end
      if (out_valid) begin
        chk("t2_data", out_data, mem[idx]);
        chk("t2_last", out_last, (idx == 3) ? 1 : 0);
        if (pat[k % 4]) idx++;
      end
      tick();
    end
    chk("t2_beats", idx, 4);
    chk("t2_done_seen", done_seen, 1);
    out_ready = 4'hF;
    tick();

    // cmd 3, len 0
    parse_done = 1'b1; cmd_in = 8'h03; len_in = 16'd0;
    tick();
    parse_done = 1'b0;
    chk("t3_start", handler_start, 4'b0100);
    chk("t3_valid_t1", out_valid, 0);
    tick();
    chk("t3_done", dispatch_done, 1);
    chk("t3_valid_t2", out_valid, 0);
    tick();
    chk("t3_busy_low", busy, 0);

    // unknown command 0x07
    parse_done = 1'b1; cmd_in = 8'h07; len_in = 16'd2;
    tick();
    parse_done = 1'b0;
    chk("t4_unknown", err_unknown_cmd, 1);
    chk("t4_no_start", handler_start, 0);
    chk("t4_busy", busy, 0);
    tick();
    chk("t4_unknown_off", err_unknown_cmd, 0);
    chk("t4_err_count", err_count, 1);

    // oversize length, parse_error coincident with the error pulse
    parse_done = 1'b1; cmd_in = 8'h01; len_in = 16'd257;
    tick();
    parse_done = 1'b0;
    parse_error = 1'b1;
    chk("t5_oversize", err_unknown_cmd, 1);
    chk("t5_no_start", handler_start, 0);
    tick();
    parse_error = 1'b0;
    chk("t5_err_count_once", err_count, 2);

    // overrun during a len 10 stream on handler 4
    for (int i = 0; i < 10; i++) mem[i] = 8'(8'h50 + i);
    out_ready = 4'hF;
    parse_done = 1'b1; cmd_in = 8'h04; len_in = 16'd10;
    tick();
    parse_done = 1'b0;
    chk("t6_start", handler_start, 4'b1000);
    tick();
    got = 0; ovr_seen = 0; start_seen = 0; done_seen = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) begin
        parse_done = 1'b1; cmd_in = 8'h01; len_in = 16'd5;
      end else begin
        parse_done = 1'b0;
      end
      if (err_overrun) ovr_seen++;
      if (k == 3) chk("t6_overrun_time", err_overrun, 1);
      if (handler_start != 0) start_seen++;
      if (dispatch_done) done_seen++;
      if (out_valid) begin
        chk("t6_data", out_data, mem[got]);
        chk("t6_last", out_last, (got == 9) ? 1 : 0);
        got++;
      end
      tick();
    end
    chk("t6_beats", got, 10);
    chk("t6_overrun_count", ovr_seen, 1);
    chk("t6_no_restart", start_seen, 0);
    chk("t6_done_count", done_seen, 1);
    chk("t6_cmd_len", cmd_len, 10);
    chk("t6_err_count", err_count, 3);

    // timeout: ready held low, limit 8
    mem[0] = 8'h9C;
    out_ready = 4'h0;
    parse_done = 1'b1; cmd_in = 8'h02; len_in = 16'd5;
    tick();
    parse_done = 1'b0;
    tick();                                   // T+2, first stalled cycle
    prev_data = out_data;
    chk("t7_first_data", prev_data, 8'h9C);
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      chk("t7_stall_valid", out_valid, 1);
      chk("t7_stall_data", out_data, prev_data);
      chk("t7_no_tmo_yet", err_timeout, 0);
      if (dispatch_done) done_seen++;
      tick();
    end
    chk("t7_timeout", err_timeout, 1);
    chk("t7_valid_drop", out_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_no_done", dispatch_done | done_seen[0], 0);
    tick();
    chk("t7_err_count", err_count, 4);

    // reset mid-stream
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    out_ready = 4'hF;
    parse_done = 1'b1; cmd_in = 8'h01; len_in = 16'd6;
    tick();
    parse_done = 1'b0;
    tick(); tick();                           // T+3, mid-stream
    chk("t8_mid_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    chk("t8_busy", busy, 0);
    chk("t8_valid", out_valid, 0);
    chk("t8_last", out_last, 0);
    chk("t8_addr", payload_read_addr, 0);
    chk("t8_cmd_len", cmd_len, 0);
    chk("t8_err_count", err_count, 0);
    rst = 1'b0;
    tick();
    chk("t8_no_done", dispatch_done, 0);
    chk("t8_no_err", {err_unknown_cmd, err_overrun, err_timeout}, 0);

    // err_count saturation
    parse_error = 1'b1;
    for (int k = 0; k < 260; k++) tick();
    chk("t9_sat", err_count, 8'hFF);
    parse_error = 1'b0;
    tick();
    chk("t9_sat_hold", err_count, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Sequencer between the UART frame parser and the command handlers. On each good frame it decodes the command byte, selects one of `NUM_HANDLERS` handlers, and streams the frame's payload out of the parser's payload buffer over a valid/ready byte stream. It owns the buffer read address while busy, rejects frames that arrive before the previous dispatch ends, and aborts dispatches stalled by a handler.

## Interface
- `NUM_HANDLERS`, 4: number of handler channels; legal cmd codes are 0x01..NUM_HANDLERS.
- `MAX_PAYLOAD_LEN`, 256: payload buffer depth in bytes.
- `ADDR_WIDTH`, $clog2(MAX_PAYLOAD_LEN): payload read address width.
- `TIMEOUT_CYCLES`, 65535: maximum consecutive stalled cycles (valid high, ready low) before abort; 16-bit counter.

Ports:
- `clk` in 1: the single clock for the block.
- `rst` in 1: synchronous, active-high reset.
- `parse_done` in 1: one-cycle pulse, frame good; `cmd_in` and `len_in` are valid in that cycle.
- `parse_error` in 1: one-cycle pulse, frame rejected by the parser.
- `cmd_in` in 8: command byte.
- `len_in` in 16: payload length in bytes.
- `payload_read_addr` out ADDR_WIDTH: read address into the parser payload buffer.
- `payload_read_data` in 8: buffer data, combinational from `payload_read_addr`.
- `handler_start` out NUM_HANDLERS: one-hot, one-cycle start pulse.
- `cmd_len` out 16: latched length of the current dispatch.
- `out_data` out 8: payload byte.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: marks the final payload byte.
- `out_ready` in NUM_HANDLERS: per-handler ready; only the selected bit is used.
- `busy` out 1: high from capture until the dispatch ends.
- `dispatch_done` out 1: one-cycle pulse on normal completion.
- `err_unknown_cmd`, `err_overrun`, `err_timeout` out 1 each: one-cycle error pulses.
- `err_count` out 8: saturating count of all error pulses plus `parse_error` pulses.

## Operation
- States: IDLE, START, STREAM, FINISH.
- IDLE
  - On `parse_done`, latch `cmd_in`, `len_in` and the selection index `cmd_in-1`.
  - If `cmd_in` is 0 or greater than NUM_HANDLERS, or `len_in` > MAX_PAYLOAD_LEN: pulse `err_unknown_cmd` next cycle and stay in IDLE. An oversized length is reported through this same signal.
  - Otherwise go to START.
- START
  - Pulse `handler_start[sel]` for one cycle; set `payload_read_addr`=0 and `busy`=1.
  - If len==0, go to FINISH; no beats are sent.
  - Otherwise go to STREAM.
- STREAM
  - `out_valid`=1.
  - `out_data` = `payload_read_data` at the current address; the address is held stable until the beat transfers.
  - A beat transfers when `out_valid` && `out_ready[sel]`; the address then increments.
  - `out_last`=1 when address == len-1.
  - Transfer of the last beat goes to FINISH.
  - Stall counter resets on each transfer and increments on each stalled cycle. When it reaches TIMEOUT_CYCLES: drop `out_valid`, pulse `err_timeout`, go to IDLE with no `dispatch_done`.
- FINISH: pulse `dispatch_done`, clear `busy`, go to IDLE.
- Overrun: `parse_done` in any state other than IDLE pulses `err_overrun`. That frame is dropped; the current dispatch continues unchanged.
- `err_count`
  - Increments by 1 per cycle in which any error pulse or `parse_error` is asserted, and saturates at 255.
  - If `parse_error` and an internal error fire in the same cycle, it increments by 1 only.
- Address arithmetic is ADDR_WIDTH bits and never wraps, because len ≤ MAX_PAYLOAD_LEN is enforced.

## Timing
- Reset: state IDLE, all pulses 0, `handler_start`=0, `out_valid`=0, `out_last`=0, `busy`=0, `cmd_len`=0, `payload_read_addr`=0, `out_data` follows the buffer, `err_count`=0, stall counter 0.
- Reset asserted mid-dispatch: outputs take reset values on the next edge; no `dispatch_done` or error pulse is issued.
- Latency, with `parse_done` in cycle T:
  - T+1: `handler_start` pulse, `busy`=1.
  - T+2: first `out_valid`.
  - With `out_ready` held high: one byte per cycle; last byte at T+1+len; `dispatch_done` at T+2+len; `busy` low from T+3+len.
- Error pulses appear the cycle after the triggering condition.
- `out_valid` and `out_data` never change while stalled, except on timeout abort.

## Test plan
- cmd=0x02, len=3, payload A1 B2 C3, ready held high -> `handler_start`=0010 at T+1; bytes A1, B2, C3 at T+2..T+4 with `out_last` on C3; `dispatch_done` at T+5; `err_count`=0.
- cmd=0x01, len=4, `out_ready[0]` toggling 1,0,0,1,... -> bytes arrive in order with no loss or duplication; data stable while stalled.
- cmd=0x03, len=0 -> `handler_start` pulse, no `out_valid`, `dispatch_done` at T+2.
- cmd=0x07 (NUM_HANDLERS=4) -> `err_unknown_cmd` at T+1; no start pulse; `err_count`=1.
- Second `parse_done` during a len=10 stream -> `err_overrun` pulse; the first stream completes intact.
- TIMEOUT_CYCLES=8, ready held low -> `err_timeout` after 8 stalled cycles; `busy`=0 and IDLE; no `dispatch_done`; `rst` pulse mid-stream returns all outputs to their reset values.
